word_byte_serializer: RTL
=========================

# word_byte_serializer

Parametrised word-to-byte serializer for the AES datapath. It accepts one N-byte word per valid/ready handshake and emits its bytes one per cycle on a valid/ready byte stream, tagging each with its index and the final byte with `out_last`. It generalises the fixed 32-bit, 4-way byte select into a width-configurable, order-configurable, flow-controlled block. It sits between the state/key word registers and the byte-wide S-box/transmit path.

## Interface
Parameters:
- `BYTES_PER_WORD`, default 4: bytes per input word. Legal range is ≥2; 16 covers a full AES block.
- `BYTE_W`, default 8: bits per byte.
- `MSB_FIRST`, default 1: 1 emits bytes most-significant first, so index 0 is bits [W-1:W-BYTE_W]. 0 emits least-significant first.

Ports (W = BYTES_PER_WORD*BYTE_W, IDX_W = max(1, clog2(BYTES_PER_WORD))):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_word`  in  W  word to serialize.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  block can accept a word.
- `out_byte`  out  BYTE_W  current byte.
- `out_idx`  out  IDX_W  position of `out_byte` in emission order (0..N-1).
- `out_last`  out  1  `out_byte` is the final byte of the word.
- `out_valid`  out  1  `out_byte`/`out_idx`/`out_last` are valid.
- `out_ready`  in  1  consumer accepts the byte.

## Operation
- The FSM, in package type `ser_state_t`, has two states: IDLE and SHIFT.
- **IDLE:**
  - `in_ready`=1 and `out_valid`=0.
  - When `in_valid`&&`in_ready`, the word is latched into `word_q`, `idx_q` is set to 0, and the FSM moves to SHIFT.
- **SHIFT:**
  - `out_valid`=1.
  - `out_byte` is the slice of `word_q` selected by `idx_q` according to `MSB_FIRST`.
  - `out_last` = (`idx_q`==N-1).
- **Byte transfer** happens when `out_valid`&&`out_ready`.
  - If `idx_q`<N-1, `idx_q` increments.
  - If `idx_q`==N-1, the FSM returns to IDLE, unless a next word is available (see Configuration).
- **Backpressure:** while `out_ready`=0, every output holds stable and `idx_q` does not advance.
- **Input side:** without prefetch, `in_ready`=0 throughout SHIFT, so an input handshake can never coincide with a transfer.
- **Outputs** are decoded only from registers (`state`, `word_q`, `idx_q`). There is no combinational path from `in_valid` or `out_ready` to any output.
- **Reset values:**
  - State is IDLE; `word_q`, `idx_q` and the skid register are 0.
  - `out_valid`=0, `out_byte`=0, `out_idx`=0, `out_last`=0.
  - `in_ready`=0 while `rst` is high, and 1 from the first cycle after.
- **Reset mid-word:** any partially sent word and any skid contents are discarded. No further bytes from them appear.

## Timing
- **Word latency:** a word accepted at edge k presents byte 0 in the cycle after edge k.
- **Byte rate:** one byte per cycle while `out_ready`=1.
- **Throughput without prefetch:** N bytes per N+1 cycles, because one IDLE bubble follows each word.
- **Throughput with prefetch:** N bytes per N cycles for back-to-back words.
- **Last-byte timing:** `out_last` is high in exactly one valid cycle per word, the cycle whose `out_idx`=N-1.

## Configuration
- Macro: `WORD_SER_PREFETCH_EN`.
- **Defined:** the block adds a one-word skid register `skid_q` with a full flag.
  - In SHIFT, `in_ready` = !`skid_full`.
  - A word accepted in SHIFT goes to `skid_q`.
  - On the last-byte transfer:
    - If `skid_full`, `skid_q` moves to `word_q`, `idx_q`=0, the FSM stays in SHIFT, and `skid_full` clears.
    - If the skid is empty and an input handshake occurs in the same cycle, the incoming word loads directly into `word_q` and the FSM stays in SHIFT.
    - Otherwise the FSM goes to IDLE.
  - In IDLE the skid is always empty.
- **Undefined:** there is no skid register, `in_ready` is 0 in SHIFT, and behaviour is exactly as described in Operation.

## Structure
- **Package `aes_ser_pkg`:**
  - `ser_state_t` (IDLE, SHIFT).
  - Helper function `idx_w(n)` returning max(1, clog2(n)).
- **Sub-module `byte_select`:**
  - Purely combinational, parametrised by `BYTES_PER_WORD`, `BYTE_W` and `MSB_FIRST`.
  - Input: word plus index. Output: selected byte.
  - An out-of-range index yields 0.
  - Instantiated once, on `word_q`/`idx_q`.

## Test plan
- **MSB-first order:** N=4, MSB_FIRST=1, `out_ready`=1, word 0xA1B2C3D4 → bytes A1, B2, C3, D4 on 4 consecutive cycles starting 1 cycle after accept; `out_idx` 0..3; `out_last` only on D4.
- **LSB-first order:** same word with MSB_FIRST=0 → D4, C3, B2, A1; `out_last` on A1.
- **Backpressure:** drop `out_ready` for 3 cycles while B2 is presented → B2 with `out_idx`=1 is held for 4 cycles, then C3 and D4 follow; there are no duplicates or drops.
- **Back-to-back words:** 0xA1B2C3D4 then 0x01020304 with `in_valid` held high.
  - Without prefetch: 8 bytes over 9 cycles after the first accept, with one `out_valid`=0 bubble after D4.
  - With `WORD_SER_PREFETCH_EN`: 8 bytes on 8 consecutive cycles.
- **Reset mid-word:** assert `rst` after 2 bytes have transferred → `out_valid`=0 and `in_ready`=0 during reset; after release, a new word 0x55667788 emits 55 with `out_idx`=0.
- **Full AES block:** N=16, word 0x00112233_44556677_8899AABB_CCDDEEFF, MSB_FIRST=1 → bytes 00 through FF in order, `out_idx` 0..15, `out_last` on FF.

Source files
------------

// File: rtl/aes_ser_pkg.sv
// Shared types for the AES word-to-byte serializer.
// Provides the FSM state type and the index-width helper.
package aes_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_byte_serializer_byte_select.sv
// byte_select: combinational byte picker for the serializer.
// Ports: i_word (word), i_idx (emission index), o_byte (selected byte).
module byte_select
  import aes_ser_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int BYTE_W         = 8,
  parameter int MSB_FIRST      = 1,
  parameter int IDX_W          = idx_w(BYTES_PER_WORD)
) (
  input  logic [BYTES_PER_WORD*BYTE_W-1:0] i_word,
  input  logic [IDX_W-1:0]                 i_idx,
  output logic [BYTE_W-1:0]                o_byte
);

  // Indices past N-1 match no slot and fall through to zero.
  always_comb begin
    o_byte = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (i_idx == IDX_W'(i)) begin
        if (MSB_FIRST != 0)
          o_byte = i_word[(BYTES_PER_WORD-1-i)*BYTE_W +: BYTE_W];
        else
          o_byte = i_word[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/word_byte_serializer.sv
// Word-to-byte serializer: one N-byte word in, N bytes out with idx/last.
// Ports: clk, rst (sync high), in_word/in_valid/in_ready,
//   out_byte/out_idx/out_last/out_valid/out_ready.
// Option: WORD_SER_PREFETCH_EN adds a one-word skid for gapless words.
module word_byte_serializer
  import aes_ser_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int BYTE_W         = 8,
  parameter int MSB_FIRST      = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [BYTES_PER_WORD*BYTE_W-1:0]      in_word,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [BYTE_W-1:0]                     out_byte,
  output logic [idx_w(BYTES_PER_WORD)-1:0]      out_idx,
  output logic                                  out_last,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int W     = BYTES_PER_WORD * BYTE_W;
  localparam int IDX_W = idx_w(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES_PER_WORD - 1);

  ser_state_t       state, state_d;
  logic [W-1:0]     word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic              w_shift;
  logic              w_is_last;
  logic              w_in_hs;
  logic              w_out_hs;
  logic [BYTE_W-1:0] w_sel;

`ifdef WORD_SER_PREFETCH_EN
  logic [W-1:0] skid_q, skid_d;
  logic         skid_full, skid_full_d;
`endif

  assign w_shift   = (state == SHIFT);
  assign w_is_last = (idx_q == LAST);
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;

`ifdef WORD_SER_PREFETCH_EN
  assign in_ready = !rst && (!w_shift || !skid_full);
`else
  assign in_ready = !rst && !w_shift;
`endif

  assign out_valid = w_shift;
  assign out_byte  = w_shift ? w_sel : '0;
  assign out_idx   = w_shift ? idx_q : '0;
  assign out_last  = w_shift && w_is_last;

  byte_select #(
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .BYTE_W         (BYTE_W),
    .MSB_FIRST      (MSB_FIRST),
    .IDX_W          (IDX_W)
  ) u_sel (
    .i_word (word_q),
    .i_idx  (idx_q),
    .o_byte (w_sel)
  );

  always_comb begin
    state_d = state;
    word_d  = word_q;
    idx_d   = idx_q;
`ifdef WORD_SER_PREFETCH_EN
    skid_d      = skid_q;
    skid_full_d = skid_full;
`endif
    unique case (state)
      IDLE: begin
        if (w_in_hs) begin
          word_d  = in_word;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
`ifdef WORD_SER_PREFETCH_EN
        // A word arriving on the last-byte transfer with an empty skid
        // bypasses the skid and loads straight into word_q below.
        if (w_in_hs && !(w_out_hs && w_is_last)) begin
          skid_d      = in_word;
          skid_full_d = 1'b1;
        end
`endif
        if (w_out_hs) begin
          if (!w_is_last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = '0;
`ifdef WORD_SER_PREFETCH_EN
            if (skid_full) begin
              word_d      = skid_q;
              skid_full_d = 1'b0;
            end else if (w_in_hs) begin
              word_d = in_word;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      word_q <= '0;
      idx_q  <= '0;
`ifdef WORD_SER_PREFETCH_EN
      skid_q    <= '0;
      skid_full <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      word_q <= word_d;
      idx_q  <= idx_d;
`ifdef WORD_SER_PREFETCH_EN
      skid_q    <= skid_d;
      skid_full <= skid_full_d;
`endif
    end
  end

endmodule
